// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD controller slice.
// Optional watchdog is enabled with the GCD_ITER_LIMIT_EN macro.
package gcd_pkg;

    localparam int DATA_W         = 16;
    localparam int ITER_W_DEF     = 16;
    localparam int ITER_LIMIT_DEF = 1000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        CALC,
        DONE
    } gcdState_t;

endpackage

// File: rtl/gcd_iter_cnt.sv
// Saturating subtraction counter for the GCD controller.
// With GCD_ITER_LIMIT_EN defined it also flags when the count reaches LIMIT.
module gcd_iter_cnt
    import gcd_pkg::*;
#(
    parameter int W = ITER_W_DEF
`ifdef GCD_ITER_LIMIT_EN
   ,parameter int LIMIT = ITER_LIMIT_DEF
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
`ifdef GCD_ITER_LIMIT_EN
   ,output logic         atLimit
`endif
);

    // Clear wins over increment; once all-ones the count sticks there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

`ifdef GCD_ITER_LIMIT_EN
    assign atLimit = (count == W'(LIMIT));
`endif

endmodule

// File: rtl/gcd_controller.sv
// Control FSM for a subtractive GCD datapath (operands loaded over a shared bus).
// Define GCD_ITER_LIMIT_EN to add a watchdog that stops after ITER_LIMIT subtractions.
module gcd_controller
    import gcd_pkg::*;
#(
    parameter int ITER_W     = ITER_W_DEF,
    parameter int ITER_LIMIT = ITER_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              data_valid,
    input  logic              data_zero,
    input  logic              gt,
    input  logic              lt,
    input  logic              eq,
    output logic              data_ready,
    output logic              ldA,
    output logic              ldB,
    output logic              selA_sub,
    output logic              selB_sub,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ITER_W-1:0] iter_count
);

    gcdState_t state, nextState;
    logic      errReg, errNext;
    logic      cntClear, cntInc;
`ifdef GCD_ITER_LIMIT_EN
    logic      atLimit;
`endif

    gcd_iter_cnt #(
        .W     (ITER_W)
`ifdef GCD_ITER_LIMIT_EN
       ,.LIMIT (ITER_LIMIT)
`endif
    ) iterCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cntClear),
        .inc   (cntInc),
        .count (iter_count)
`ifdef GCD_ITER_LIMIT_EN
       ,.atLimit (atLimit)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            errReg <= 1'b0;
        end else begin
            state  <= nextState;
            errReg <= errNext;
        end
    end

    // Next state and all control outputs; abort overrides everything at the end.
    always_comb begin
        nextState  = state;
        errNext    = errReg;
        data_ready = 1'b0;
        ldA        = 1'b0;
        ldB        = 1'b0;
        selA_sub   = 1'b0;
        selB_sub   = 1'b0;
        cntClear   = 1'b0;
        cntInc     = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    nextState = LOAD_A;
                    cntClear  = 1'b1;
                    errNext   = 1'b0;
                end
            end
            LOAD_A: begin
                data_ready = 1'b1;
                if (data_valid) begin
                    ldA = 1'b1;
                    if (data_zero) begin
                        errNext   = 1'b1;
                        nextState = DONE;
                    end else begin
                        nextState = LOAD_B;
                    end
                end
            end
            LOAD_B: begin
                data_ready = 1'b1;
                if (data_valid) begin
                    ldB = 1'b1;
                    if (data_zero) begin
                        errNext   = 1'b1;
                        nextState = DONE;
                    end else begin
                        nextState = CALC;
                    end
                end
            end
            CALC: begin
                if (eq) begin
                    nextState = DONE;
`ifdef GCD_ITER_LIMIT_EN
                end else if (atLimit) begin
                    errNext   = 1'b1;
                    nextState = DONE;
`endif
                end else if (gt) begin
                    ldA      = 1'b1;
                    selA_sub = 1'b1;
                    cntInc   = 1'b1;
                end else if (lt) begin
                    ldB      = 1'b1;
                    selB_sub = 1'b1;
                    cntInc   = 1'b1;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase

        // An aborted cycle must not disturb the datapath, counter or error flag.
        if (abort) begin
            nextState = IDLE;
            errNext   = errReg;
            ldA       = 1'b0;
            ldB       = 1'b0;
            selA_sub  = 1'b0;
            selB_sub  = 1'b0;
            cntClear  = 1'b0;
            cntInc    = 1'b0;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign err  = errReg;

endmodule

// File: tb/tb_gcd_controller.sv
// Self-checking bench for gcd_controller: table-driven operations plus abort and reset sequences.
// Expectations for the long operand pair depend on GCD_ITER_LIMIT_EN.
module tb_gcd_controller;
    import gcd_pkg::*;

    localparam int ITER_W  = 16;
    localparam int LIMIT   = 100;
    localparam int MAX_CYC = 70000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, abort, data_valid;
    logic              data_zero, gt, lt, eq;
    logic              data_ready, ldA, ldB, selA_sub, selB_sub;
    logic              busy, done, err;
    logic [ITER_W-1:0] iter_count;
    logic [15:0]       bus, regA, regB;

    int nChecks = 0;
    int nFail   = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          stallA;
        int          stallB;
        bit          noise;
        logic [15:0] expResult;
        int          expIter;
        bit          expErr;
        int          expLat;
        int          expPhases;
    } vec_t;

    vec_t vecs[$];
    int   latency, phases;

    gcd_controller #(.ITER_W(ITER_W), .ITER_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .data_valid (data_valid),
        .data_zero  (data_zero),
        .gt         (gt),
        .lt         (lt),
        .eq         (eq),
        .data_ready (data_ready),
        .ldA        (ldA),
        .ldB        (ldB),
        .selA_sub   (selA_sub),
        .selB_sub   (selB_sub),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .iter_count (iter_count)
    );

    always #5 clk = ~clk;

    // Behavioural datapath: operand registers, subtractors and comparators.
    always @(posedge clk) begin
        if (ldA) regA <= selA_sub ? regA - regB : bus;
        if (ldB) regB <= selB_sub ? regB - regA : bus;
    end

    assign data_zero = (bus == 16'd0);
    assign gt        = (regA > regB);
    assign lt        = (regA < regB);
    assign eq        = (regA == regB);

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Runs one operation from the start cycle (cycle 0) until done or the cycle budget.
    task automatic applyStimulus(input vec_t v, output int lat, output int ph);
        int stall = 0;
        int cyc;
        lat = -1;
        ph  = 0;
        @(negedge clk);
        start = 1'b1;
        cyc   = 0;
        @(negedge clk);
        cyc = 1;
        while (cyc < MAX_CYC) begin
            data_valid = 1'b0;
            if (data_ready) begin
                if (stall < ((ph == 0) ? v.stallA : v.stallB)) begin
                    stall++;
                end else begin
                    data_valid = 1'b1;
                    bus        = (ph == 0) ? v.a : v.b;
                end
            end
            #1;
            if (data_ready && !data_valid && (ldA || ldB))
                checkOutput("load during stall", 1, 0);
            if (done) begin
                lat = cyc;
                break;
            end
            if (data_ready && data_valid) begin
                ph++;
                stall = 0;
            end
            start = v.noise ? cyc[0] : 1'b0;
            @(negedge clk);
            cyc++;
        end
        start      = 1'b0;
        data_valid = 1'b0;
    endtask

    // Starts an operation and feeds both operands without stalls; returns in the first CALC cycle.
    task automatic loadOperands(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        data_valid = 1'b1;
        bus        = a;
        @(negedge clk);
        bus = b;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        data_valid = 1'b0;
        bus        = 16'd0;

        //                a      b     stA stB noise res   iter  err lat phases
        vecs.push_back('{16'd48, 16'd18, 0, 0, 1'b0, 16'd6,  4, 1'b0,  8, 2});
        vecs.push_back('{16'd7,  16'd7,  0, 0, 1'b0, 16'd7,  0, 1'b0,  4, 2});
        vecs.push_back('{16'd0,  16'd9,  0, 0, 1'b0, 16'd0,  0, 1'b1,  2, 1});
        vecs.push_back('{16'd5,  16'd0,  0, 0, 1'b0, 16'd0,  0, 1'b1,  3, 2});
        vecs.push_back('{16'd48, 16'd18, 3, 2, 1'b1, 16'd6,  4, 1'b0, 13, 2});
        vecs.push_back('{16'd12, 16'd18, 0, 0, 1'b0, 16'd6,  2, 1'b0,  6, 2});
        vecs.push_back('{16'd1,  16'd10, 0, 0, 1'b0, 16'd1,  9, 1'b0, 13, 2});
        vecs.push_back('{16'd21, 16'd14, 0, 0, 1'b1, 16'd7,  2, 1'b0,  6, 2});
        vecs.push_back('{16'd100,16'd75, 0, 0, 1'b0, 16'd25, 3, 1'b0,  7, 2});
`ifdef GCD_ITER_LIMIT_EN
        vecs.push_back('{16'd65535, 16'd1, 0, 0, 1'b0, 16'd0, 100, 1'b1, 104, 2});
`else
        vecs.push_back('{16'd65535, 16'd1, 0, 0, 1'b0, 16'd1, 65534, 1'b0, 65538, 2});
`endif

        #12;
        checkOutput("reset busy",       int'(busy), 0);
        checkOutput("reset done",       int'(done), 0);
        checkOutput("reset err",        int'(err), 0);
        checkOutput("reset data_ready", int'(data_ready), 0);
        checkOutput("reset controls",   int'({ldA, ldB, selA_sub, selB_sub}), 0);
        checkOutput("reset iter_count", int'(iter_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], latency, phases);
            checkOutput($sformatf("vec%0d latency", i), latency, vecs[i].expLat);
            checkOutput($sformatf("vec%0d err", i), int'(err), int'(vecs[i].expErr));
            checkOutput($sformatf("vec%0d iter_count", i), int'(iter_count), vecs[i].expIter);
            checkOutput($sformatf("vec%0d operands taken", i), phases, vecs[i].expPhases);
            if (!vecs[i].expErr)
                checkOutput($sformatf("vec%0d result", i), int'(regA), int'(vecs[i].expResult));
            @(negedge clk);
            checkOutput($sformatf("vec%0d done pulse width", i), int'(done), 0);
            checkOutput($sformatf("vec%0d idle after done", i), int'(busy), 0);
            checkOutput($sformatf("vec%0d err hold", i), int'(err), int'(vecs[i].expErr));
            checkOutput($sformatf("vec%0d iter hold", i), int'(iter_count), vecs[i].expIter);
        end

        // Abort during a long CALC: back to IDLE next cycle and no done afterwards.
        loadOperands(16'd65535, 16'd1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort pre busy", int'(busy), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort to idle", int'(busy), 0);
        checkOutput("abort no done", int'(done), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("abort stays idle %0d", k), int'({busy, done}), 0);
        end

        // Asynchronous reset in the middle of CALC clears every output at once.
        loadOperands(16'd65535, 16'd1);
        @(negedge clk);
        #1;
        checkOutput("calc subtract A", int'({ldA, selA_sub}), 3);
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset busy",     int'(busy), 0);
        checkOutput("mid reset controls", int'({data_ready, ldA, ldB, selA_sub, selB_sub}), 0);
        checkOutput("mid reset done/err", int'({done, err}), 0);
        checkOutput("mid reset iter",     int'(iter_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post reset idle", int'({busy, done}), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
